seg_reader: RTL and testbench
=============================

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required to accept a digit; legal range 2..255.
REQ-002 CLK  input  1  single clock; all state on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 SEG  input  7  segment lines, active-high, bit order identical to the team's digit encoder DISPLAY[6:0].
REQ-005 SEL  input  4  digit-select lines, active-high, one-hot; SEL[i] selects digit position i.
REQ-006 NUM  output  16  four captured BCD digits; NUM[4i+3:4i] is position i.
REQ-007 VALID  output  1  one-cycle pulse when NUM is updated with a complete frame.
REQ-008 ERR  output  1  high when the last completed frame contained an illegal pattern; held until the next frame completes.

Function
REQ-009 SEG and SEL shall each pass through a two-flop synchronizer before any other use.
REQ-010 Legal patterns (hex, SEG[6:0]) shall decode as: 6F->0, 24->1, 5E->2, 76->3, 35->4, 73->5, 7B->6, 26->7, 7F->8, 77->9.
REQ-011 Any other pattern shall be illegal: it decodes to 4'hF and sets the per-frame error flag.
REQ-012 FSM states WAIT, COUNT, LOCKED.
REQ-013 WAIT: synchronized SEL one-hot -> COUNT, counter=1; otherwise remain.
REQ-014 COUNT: sample equal to previous {SEL,SEG} -> counter+1; sample differs -> counter=1 if SEL one-hot, else WAIT.
REQ-015 COUNT: counter reaching STABLE_CYCLES -> accept strobe for one cycle, go LOCKED.
REQ-016 LOCKED: any change of synchronized {SEL,SEG} -> COUNT (counter=1) if SEL one-hot, else WAIT; one acceptance per dwell.
REQ-017 Accept: decoded digit written to frame buffer slot of SEL, captured bit for that slot set; re-capture of a slot before frame completion overwrites it.
REQ-018 When the accept sets the last uncaptured bit, the next edge shall load NUM from the frame buffer (including the just-accepted digit), pulse VALID, load ERR with the frame error flag, and clear captured bits and error flag.
REQ-019 A pin pattern held STABLE_CYCLES+3 cycles shall always be accepted; one held at most STABLE_CYCLES-1 cycles shall never be accepted.
REQ-020 SEL zero or multi-hot shall never cause acceptance and shall not clear captured bits.

Reset
REQ-021 RST_N low shall asynchronously force NUM=0, VALID=0, ERR=0, captured bits=0, frame error=0, counter=0, FSM=WAIT, synchronizers=0.
REQ-022 Reset mid-frame shall discard the partial frame; no VALID until four fresh accepts after release.

Configuration
REQ-023 Macro SEG_READER_BLANK_EN defined: pattern 00 shall decode to 4'hA (blank) and be legal.
REQ-024 Macro undefined: pattern 00 shall be illegal per REQ-011.

Structure
REQ-025 Package seg_pkg shall hold the ten segment-pattern constants, the blank and illegal digit codes, and the digit count (4).
REQ-026 Sub-module seg_decode shall be the combinational pattern-to-digit/legal decoder, shared with any future encoder checks.

Verification
REQ-027 Scan digits 1,2,3,4 on positions 0..3, each held 10 cycles, STABLE_CYCLES=4 -> one VALID pulse, NUM=16'h4321, ERR=0.
REQ-028 Position 2 driven with 7'h7C, others legal -> VALID, NUM[11:8]=4'hF, ERR=1; next clean frame -> ERR=0.
REQ-029 Glitch: pattern held 3 cycles then changed -> no accept; same pattern held 7 cycles -> accepted.
REQ-030 SEL=4'b0011 for 20 cycles mid-frame -> no accept, captured bits retained, frame completes after remaining digits.
REQ-031 RST_N pulsed low after three accepts -> outputs zero immediately; VALID only after four new accepts.
REQ-032 SEG=00 on position 1: with SEG_READER_BLANK_EN NUM[7:4]=4'hA, ERR=0; without, NUM[7:4]=4'hF, ERR=1.

Source files
------------

// File: rtl/seg_pkg.sv
// ============================================================================
// Package  : seg_pkg
// Brief    : Shared seven-segment pattern constants, digit codes and helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int          C_NUM_DIGITS    = 4;

    localparam logic [6:0]  C_SEG_0         = 7'h6F;
    localparam logic [6:0]  C_SEG_1         = 7'h24;
    localparam logic [6:0]  C_SEG_2         = 7'h5E;
    localparam logic [6:0]  C_SEG_3         = 7'h76;
    localparam logic [6:0]  C_SEG_4         = 7'h35;
    localparam logic [6:0]  C_SEG_5         = 7'h73;
    localparam logic [6:0]  C_SEG_6         = 7'h7B;
    localparam logic [6:0]  C_SEG_7         = 7'h26;
    localparam logic [6:0]  C_SEG_8         = 7'h7F;
    localparam logic [6:0]  C_SEG_9         = 7'h77;
    localparam logic [6:0]  C_SEG_BLANK     = 7'h00;

    localparam logic [3:0]  C_DIGIT_BLANK   = 4'hA;
    localparam logic [3:0]  C_DIGIT_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_LOCKED = 2'd2
    } rd_state_t;

    function automatic logic is_onehot(input logic [C_NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [C_NUM_DIGITS-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < C_NUM_DIGITS; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// ============================================================================
// Module   : seg_decode
// Brief    : Combinational seven-segment pattern to BCD digit / legality decoder.
// Options  : SEG_READER_BLANK_EN - pattern 7'h00 decodes to blank (4'hA), legal.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = C_DIGIT_ILLEGAL;
        legal = 1'b0;
        case (seg)
            C_SEG_0: begin digit = 4'd0; legal = 1'b1; end
            C_SEG_1: begin digit = 4'd1; legal = 1'b1; end
            C_SEG_2: begin digit = 4'd2; legal = 1'b1; end
            C_SEG_3: begin digit = 4'd3; legal = 1'b1; end
            C_SEG_4: begin digit = 4'd4; legal = 1'b1; end
            C_SEG_5: begin digit = 4'd5; legal = 1'b1; end
            C_SEG_6: begin digit = 4'd6; legal = 1'b1; end
            C_SEG_7: begin digit = 4'd7; legal = 1'b1; end
            C_SEG_8: begin digit = 4'd8; legal = 1'b1; end
            C_SEG_9: begin digit = 4'd9; legal = 1'b1; end
`ifdef SEG_READER_BLANK_EN
            C_SEG_BLANK: begin digit = C_DIGIT_BLANK; legal = 1'b1; end
`endif
            default: begin
                digit = C_DIGIT_ILLEGAL;
                legal = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_reader.sv
// ============================================================================
// Module   : seg_reader
// Brief    : Samples a multiplexed 4-digit seven-segment display and rebuilds
//            the displayed BCD number once every position has been seen stable.
// Options  : SEG_READER_BLANK_EN - accept the all-off pattern as a blank digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  sel,
    output logic [15:0] num,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  r_seg_meta, r_seg_sync;
    logic [3:0]  r_sel_meta, r_sel_sync;
    logic [10:0] r_prev;
    rd_state_t   r_state;
    logic [7:0]  r_count;

    logic        r_acc;
    logic [1:0]  r_acc_slot;
    logic [3:0]  r_acc_digit;
    logic        r_acc_illegal;

    logic [15:0] r_buf;
    logic [3:0]  r_captured;
    logic        r_frame_err;

    logic [10:0] w_sample;
    logic        w_same;
    logic        w_onehot;
    logic [1:0]  w_slot;
    logic [3:0]  w_digit;
    logic        w_legal;
    logic [3:0]  w_cap_next;
    logic [15:0] w_frame;

    // Pins are asynchronous to clk; nothing downstream looks at the raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_meta <= '0;
            r_seg_sync <= '0;
            r_sel_meta <= '0;
            r_sel_sync <= '0;
        end else begin
            r_seg_meta <= seg;
            r_seg_sync <= r_seg_meta;
            r_sel_meta <= sel;
            r_sel_sync <= r_sel_meta;
        end
    end

    assign w_sample = {r_sel_sync, r_seg_sync};
    assign w_same   = (w_sample == r_prev);
    assign w_onehot = is_onehot(r_sel_sync);
    assign w_slot   = onehot_index(r_sel_sync);

    seg_decode u_decode (
        .seg   (r_seg_sync),
        .digit (w_digit),
        .legal (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT;
            r_count       <= '0;
            r_prev        <= '0;
            r_acc         <= 1'b0;
            r_acc_slot    <= '0;
            r_acc_digit   <= '0;
            r_acc_illegal <= 1'b0;
        end else begin
            r_prev <= w_sample;
            r_acc  <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    if (w_onehot) begin
                        r_state <= ST_COUNT;
                        r_count <= 8'd1;
                    end
                end
                ST_COUNT: begin
                    if (w_same) begin
                        if (r_count + 8'd1 == C_STABLE) begin
                            r_state       <= ST_LOCKED;
                            r_count       <= C_STABLE;
                            r_acc         <= 1'b1;
                            r_acc_slot    <= w_slot;
                            r_acc_digit   <= w_digit;
                            r_acc_illegal <= ~w_legal;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end else if (w_onehot) begin
                        r_count <= 8'd1;
                    end else begin
                        r_state <= ST_WAIT;
                        r_count <= '0;
                    end
                end
                ST_LOCKED: begin
                    // Stay locked for the rest of this dwell so it is accepted once.
                    if (!w_same) begin
                        if (w_onehot) begin
                            r_state <= ST_COUNT;
                            r_count <= 8'd1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_count <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_cap_next = r_captured | (4'b0001 << r_acc_slot);
        w_frame    = r_buf;
        w_frame[{r_acc_slot, 2'b00} +: 4] = r_acc_digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_captured  <= '0;
            r_frame_err <= 1'b0;
            num         <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (r_acc) begin
                r_buf <= w_frame;
                if (&w_cap_next) begin
                    num         <= w_frame;
                    valid       <= 1'b1;
                    err         <= r_frame_err | r_acc_illegal;
                    r_captured  <= '0;
                    r_frame_err <= 1'b0;
                end else begin
                    r_captured  <= w_cap_next;
                    r_frame_err <= r_frame_err | r_acc_illegal;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_reader.sv
// ============================================================================
// Module   : tb_seg_reader
// Brief    : Self-checking bench for seg_reader: directed scenarios plus random
//            pin dwells scored against a dwell-level reference model.
// Options  : SEG_READER_BLANK_EN - expected decode of the all-off pattern.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg_reader;

    localparam int S = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg   = '0;
    logic [3:0]  sel   = '0;
    logic [15:0] num;
    logic        valid;
    logic        err;

    seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (seg),
        .sel   (sel),
        .num   (num),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed { logic [15:0] num; logic err; } frame_t;
    frame_t exp_q[$];
    frame_t obs_q[$];

    logic [6:0] pats [10] = '{7'h6F, 7'h24, 7'h5E, 7'h76, 7'h35,
                              7'h73, 7'h7B, 7'h26, 7'h7F, 7'h77};

    // Reference model: a dwell is a run of identical pin patterns; a one-hot
    // dwell of at least S cycles yields exactly one accepted digit.
    logic [10:0] m_last;
    int          m_run;
    bit          m_taken;
    logic [3:0]  m_buf [4];
    bit          m_cap [4];
    bit          m_ferr;

    always @(negedge clk) begin
        if (valid === 1'b1) obs_q.push_back({num, err});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d, output bit ok);
        d  = 4'hF;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (pats[k] == p) begin d = 4'(k); ok = 1'b1; end
        end
`ifdef SEG_READER_BLANK_EN
        if (p == 7'h00) begin d = 4'hA; ok = 1'b1; end
`endif
    endfunction

    task automatic model_reset();
        m_last  = '0;
        m_run   = 0;
        m_taken = 1'b0;
        m_ferr  = 1'b0;
        for (int k = 0; k < 4; k++) begin m_cap[k] = 1'b0; m_buf[k] = '0; end
    endtask

    task automatic model_accept(input logic [3:0] s, input logic [6:0] p);
        logic [3:0] d;
        bit ok;
        int slot;
        slot = 0;
        for (int k = 0; k < 4; k++) if (s[k]) slot = k;
        ref_decode(p, d, ok);
        m_buf[slot] = d;
        m_cap[slot] = 1'b1;
        if (!ok) m_ferr = 1'b1;
        if (m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3]) begin
            exp_q.push_back({m_buf[3], m_buf[2], m_buf[1], m_buf[0], m_ferr});
            for (int k = 0; k < 4; k++) m_cap[k] = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    // Called at a falling edge; drives the pins for d rising edges.
    task automatic hold(input logic [3:0] s, input logic [6:0] p, input int d);
        sel = s;
        seg = p;
        if ({s, p} == m_last) m_run += d;
        else begin m_last = {s, p}; m_run = d; m_taken = 1'b0; end
        if ($countones(s) == 1 && !m_taken && m_run >= S) begin
            m_taken = 1'b1;
            model_accept(s, p);
        end
        repeat (d) @(negedge clk);
    endtask

    task automatic idle(input int d);
        hold(4'b0000, 7'h00, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (num !== 16'h0) begin n_err++; $display("FAIL reset_num: got %h want 0000", num); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        idle(5);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", valid); end
    endtask

    task automatic test_scan();
        frame_t o;
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[1], 10);
        hold(4'b0010, pats[2], 10);
        hold(4'b0100, pats[3], 10);
        hold(4'b1000, pats[4], 10);
        idle(12);
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL scan_pulses: got %0d want 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++; if (o.num !== 16'h4321) begin n_err++; $display("FAIL scan_num: got %h want 4321", o.num); end
        n_vec++; if (o.err !== 1'b0) begin n_err++; $display("FAIL scan_err: got %b want 0", o.err); end
        n_vec++; if (num !== 16'h4321) begin n_err++; $display("FAIL scan_num_held: got %h want 4321", num); end
    endtask

    task automatic test_illegal();
        frame_t o0, o1;
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[5], 10);
        hold(4'b0010, pats[6], 10);
        hold(4'b0100, 7'h7C,   10);
        hold(4'b1000, pats[8], 10);
        idle(12);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err_held: got %b want 1", err); end
        hold(4'b0001, pats[1], 10);
        hold(4'b0010, pats[2], 10);
        hold(4'b0100, pats[3], 10);
        hold(4'b1000, pats[4], 10);
        idle(12);
        n_vec++; if (obs_q.size() != 2) begin n_err++; $display("FAIL illegal_pulses: got %0d want 2", obs_q.size()); end
        o0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        o1 = (obs_q.size() > 1) ? obs_q[1] : '1;
        n_vec++; if (o0.num !== 16'h8F65) begin n_err++; $display("FAIL illegal_num: got %h want 8f65", o0.num); end
        n_vec++; if (o0.err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %b want 1", o0.err); end
        n_vec++; if (o1.err !== 1'b0) begin n_err++; $display("FAIL clean_err: got %b want 0", o1.err); end
    endtask

    task automatic test_glitch();
        frame_t o;
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[9], 10);
        hold(4'b0010, pats[8], 10);
        hold(4'b0100, pats[7], 10);
        hold(4'b1000, pats[6], S - 1);
        idle(10);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL glitch_accepted: got %0d pulses want 0", obs_q.size()); end
        hold(4'b1000, pats[6], S + 3);
        idle(12);
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL glitch_pulses: got %0d want 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++; if (o.num !== 16'h6789) begin n_err++; $display("FAIL glitch_num: got %h want 6789", o.num); end
    endtask

    task automatic test_multihot();
        frame_t o;
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[2], 10);
        hold(4'b0010, pats[5], 10);
        hold(4'b0011, pats[8], 20);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL multihot_pulse: got %0d want 0", obs_q.size()); end
        hold(4'b0100, pats[1], 10);
        hold(4'b1000, pats[0], 10);
        idle(12);
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL multihot_pulses: got %0d want 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++; if (o.num !== 16'h0152) begin n_err++; $display("FAIL multihot_num: got %h want 0152", o.num); end
    endtask

    task automatic test_reset_midframe();
        frame_t o;
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[1], 10);
        hold(4'b0010, pats[2], 10);
        hold(4'b0100, pats[3], 10);
        idle(8);
        rst_n = 1'b0;
        #1;
        n_vec++; if (num !== 16'h0) begin n_err++; $display("FAIL midreset_num: got %h want 0000", num); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL midreset_err: got %b want 0", err); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1000, pats[4], 10);
        idle(12);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL midreset_early: got %0d pulses want 0", obs_q.size()); end
        hold(4'b0001, pats[5], 10);
        hold(4'b0010, pats[6], 10);
        hold(4'b0100, pats[7], 10);
        idle(12);
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL midreset_pulses: got %0d want 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++; if (o.num !== 16'h4765) begin n_err++; $display("FAIL midreset_num2: got %h want 4765", o.num); end
    endtask

    task automatic test_blank();
        frame_t o;
        logic [3:0] want_d;
        logic want_e;
`ifdef SEG_READER_BLANK_EN
        want_d = 4'hA; want_e = 1'b0;
`else
        want_d = 4'hF; want_e = 1'b1;
`endif
        obs_q.delete(); exp_q.delete();
        hold(4'b0001, pats[3], 10);
        hold(4'b0010, 7'h00,   10);
        hold(4'b0100, pats[1], 10);
        hold(4'b1000, pats[2], 10);
        idle(12);
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++; if (o.num[7:4] !== want_d) begin n_err++; $display("FAIL blank_digit: got %h want %h", o.num[7:4], want_d); end
        n_vec++; if (o.err !== want_e) begin n_err++; $display("FAIL blank_err: got %b want %b", o.err, want_e); end
    endtask

    task automatic test_random();
        frame_t o, e;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 150; i++) begin
            logic [3:0] s;
            logic [6:0] p;
            int d;
            if ($urandom_range(0, 9) < 8) s = 4'b0001 << $urandom_range(0, 3);
            else s = 4'($urandom);
            if ($urandom_range(0, 9) < 8) p = pats[$urandom_range(0, 9)];
            else p = 7'($urandom);
            if ({s, p} == m_last) p = p ^ 7'h01;
            d = ($urandom_range(0, 1) == 1) ? $urandom_range(1, S - 1) : $urandom_range(S + 3, S + 6);
            hold(s, p, d);
        end
        idle(12);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random_frames: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random_frame: got num=%h err=%b want num=%h err=%b", o.num, o.err, e.num, e.err);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_illegal();
        test_glitch();
        test_multihot();
        test_reset_midframe();
        test_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
